// File: rtl/pcm_tx_pkg.sv
// Shared widths and state encoding for the serial PCM transmitter.
package pcm_tx_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned FRAME_BITS = 32;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock first-word-fall-through FIFO; full/empty are registered flags.
module sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             NRESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign w_do_pop  = pop & ~r_empty;
  assign w_do_push = push & (~r_full | w_do_pop);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge CLK or negedge NRESET) begin
    if (!NRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/pcm_serial_tx.sv
// Buffers mono PCM samples and shifts each one out twice (left, right slot) as a
// left-justified SCLK/LRCLK/SDATA frame.
module pcm_serial_tx
  import pcm_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                NRESET,
  input  logic                ENABLE,
  input  logic                I_DV,
  input  logic [SAMPLE_W-1:0] DI,
  output logic                I_RDY,
  output logic                O_OVF,
  output logic                O_UNF,
  output logic                SCLK,
  output logic                LRCLK,
  output logic                SDATA
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(FRAME_BITS);

  state_e              r_state;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [SAMPLE_W-1:0] r_sample;
  logic                r_sclk;
  logic                r_lrclk;
  logic                r_sdata;
  logic                r_ovf;
  logic                r_unf;

  logic [SAMPLE_W-1:0] w_fifo_dout;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_div_wrap;
  logic                w_boundary;
  logic                w_frame_start;
  logic [BIT_W-1:0]    w_bit_nxt;

  assign w_div_wrap    = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_boundary    = (r_state == RUN) & w_div_wrap & r_sclk &
                         (r_bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign w_frame_start = ENABLE & ((r_state == IDLE) | w_boundary);
  assign w_bit_nxt     = r_bit_cnt + 1'b1;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK    (CLK),
    .NRESET (NRESET),
    .push   (I_DV),
    .pop    (w_frame_start),
    .din    (DI),
    .dout   (w_fifo_dout),
    .full   (w_fifo_full),
    .empty  (w_fifo_empty)
  );

  always_ff @(posedge CLK or negedge NRESET) begin
    if (!NRESET) begin
      r_state   <= IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_sample  <= '0;
      r_sclk    <= 1'b0;
      r_lrclk   <= 1'b0;
      r_sdata   <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      // Full is only relieved by the frame-start pop on this same edge.
      r_ovf <= I_DV & w_fifo_full & ~w_frame_start;
      r_unf <= 1'b0;
      if (w_frame_start) begin
        r_state   <= RUN;
        r_sample  <= w_fifo_empty ? '0 : w_fifo_dout;
        r_unf     <= w_fifo_empty;
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
        r_sclk    <= 1'b0;
        r_lrclk   <= 1'b0;
        r_sdata   <= ~w_fifo_empty & w_fifo_dout[SAMPLE_W-1];
      end else if (r_state == RUN) begin
        if (w_div_wrap) begin
          r_div_cnt <= '0;
          r_sclk    <= ~r_sclk;
          if (r_sclk) begin
            if (w_boundary) begin
              r_state   <= IDLE;
              r_bit_cnt <= '0;
              r_lrclk   <= 1'b0;
              r_sdata   <= 1'b0;
            end else begin
              // Index wraps at 16 so the right slot replays the same sample.
              r_bit_cnt <= w_bit_nxt;
              r_lrclk   <= w_bit_nxt[BIT_W-1];
              r_sdata   <= r_sample[~w_bit_nxt[BIT_W-2:0]];
            end
          end
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end
    end
  end

  assign I_RDY = ~w_fifo_full;
  assign O_OVF = r_ovf;
  assign O_UNF = r_unf;
  assign SCLK  = r_sclk;
  assign LRCLK = r_lrclk;
  assign SDATA = r_sdata;

endmodule

// File: tb/tb_pcm_serial_tx.sv
// Directed bench for pcm_serial_tx: expected frames are queued by the stimulus and
// checked by a monitor that deserialises SDATA on SCLK rising edges.
module tb_pcm_serial_tx;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  logic        CLK    = 1'b0;
  logic        NRESET = 1'b1;
  logic        ENABLE = 1'b0;
  logic        I_DV   = 1'b0;
  logic [15:0] DI     = '0;
  logic        I_RDY;
  logic        O_OVF;
  logic        O_UNF;
  logic        SCLK;
  logic        LRCLK;
  logic        SDATA;

  typedef struct packed {
    logic [15:0] sample;
    logic        unf;
  } frame_t;

  frame_t exp_q[$];
  int     n_checks    = 0;
  int     n_fail      = 0;
  int     frames_done = 0;
  int     exp_total   = 0;

  always #5 CLK = ~CLK;

  pcm_serial_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK    (CLK),
    .NRESET (NRESET),
    .ENABLE (ENABLE),
    .I_DV   (I_DV),
    .DI     (DI),
    .I_RDY  (I_RDY),
    .O_OVF  (O_OVF),
    .O_UNF  (O_UNF),
    .SCLK   (SCLK),
    .LRCLK  (LRCLK),
    .SDATA  (SDATA)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait expired", name);
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push(input logic [15:0] v);
    I_DV = 1'b1;
    DI   = v;
    @(negedge CLK);
    I_DV = 1'b0;
  endtask

  task automatic expect_frame(input logic [15:0] s, input logic unf);
    frame_t f;
    f.sample = s;
    f.unf    = unf;
    exp_q.push_back(f);
    exp_total++;
  endtask

  task automatic wait_frames(input int target);
    int c = 0;
    while (frames_done < target && c < 20000) begin
      @(negedge CLK);
      c++;
    end
    if (frames_done < target) timeout_fail("frame wait");
  endtask

  task automatic wait_falls(input int n);
    int   cnt = 0;
    int   c   = 0;
    logic prev;
    prev = SCLK;
    while (cnt < n && c < 5000) begin
      @(negedge CLK);
      c++;
      if (prev && !SCLK) cnt++;
      prev = SCLK;
    end
    if (cnt < n) timeout_fail("sclk fall wait");
  endtask

  // Let frames run until the last queued one is in flight, then stop after it.
  task automatic run_until_last();
    wait_frames(exp_total - 1);
    repeat (20) @(negedge CLK);
    ENABLE = 1'b0;
    wait_frames(exp_total);
    repeat (8) @(negedge CLK);
  endtask

  task automatic check_idle(input string name);
    int bad = 0;
    repeat (64) begin
      @(negedge CLK);
      if (SCLK || LRCLK || SDATA) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin : monitor
    logic        prev;
    int          nbits;
    logic [31:0] data;
    logic [31:0] lr;
    logic        unf_seen;
    frame_t      e;
    prev     = 1'b0;
    nbits    = 0;
    data     = '0;
    lr       = '0;
    unf_seen = 1'b0;
    forever begin
      @(negedge CLK);
      if (!NRESET) begin
        prev     = 1'b0;
        nbits    = 0;
        unf_seen = 1'b0;
      end else begin
        if (O_UNF) unf_seen = 1'b1;
        if (!prev && SCLK) begin
          data = {data[30:0], SDATA};
          lr   = {lr[30:0], LRCLK};
          nbits++;
          if (nbits == 32) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected frame: got %h, required none", data);
            end else begin
              e = exp_q.pop_front();
              check("left slot", {16'h0, data[31:16]}, {16'h0, e.sample});
              check("right slot", {16'h0, data[15:0]}, {16'h0, e.sample});
              check("lrclk pattern", lr, 32'h0000_FFFF);
              check("underflow flag", {31'h0, unf_seen}, {31'h0, e.unf});
            end
            nbits    = 0;
            unf_seen = 1'b0;
            frames_done++;
          end
        end
        prev = SCLK;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   cyc;
    int   falls;
    logic prev;

    // Reset
    #2 NRESET = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset I_RDY", I_RDY, 1);
    check("reset SCLK", SCLK, 0);
    check("reset LRCLK", LRCLK, 0);
    check("reset SDATA", SDATA, 0);
    check("reset O_OVF", O_OVF, 0);
    check("reset O_UNF", O_UNF, 0);
    NRESET = 1'b1;
    @(negedge CLK);

    // Basic frame and its length
    push(16'h8001);
    expect_frame(16'h8001, 1'b0);
    ENABLE = 1'b1;
    @(negedge CLK);
    check("basic O_UNF", O_UNF, 0);
    prev  = SCLK;
    cyc   = 0;
    falls = 0;
    while (falls < 32 && cyc < 1000) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 3) ENABLE = 1'b0;
      if (prev && !SCLK) falls++;
      prev = SCLK;
    end
    check("basic frame length", cyc, 128);
    wait_frames(exp_total);
    check_idle("basic idle");

    // Overflow with ENABLE low
    for (int i = 1; i <= 4; i++) begin
      push(16'(i));
      expect_frame(16'(i), 1'b0);
      check($sformatf("I_RDY after push %0d", i), I_RDY, (i < 4) ? 1 : 0);
    end
    push(16'h0005);
    check("O_OVF on 5th push", O_OVF, 1);
    @(negedge CLK);
    check("O_OVF single pulse", O_OVF, 0);
    check("I_RDY while full", I_RDY, 0);
    expect_frame(16'h0000, 1'b1);
    ENABLE = 1'b1;
    run_until_last();
    check_idle("overflow idle");

    // Underflow, then a sample pushed mid-frame
    expect_frame(16'h0000, 1'b1);
    ENABLE = 1'b1;
    @(negedge CLK);
    check("O_UNF first clk", O_UNF, 1);
    @(negedge CLK);
    check("O_UNF single pulse", O_UNF, 0);
    repeat (40) @(negedge CLK);
    push(16'h7FFF);
    expect_frame(16'h7FFF, 1'b0);
    run_until_last();
    check_idle("underflow idle");

    // Stop mid-frame at bit 5; second sample stays queued
    push(16'hA5C3);
    push(16'h3C5A);
    expect_frame(16'hA5C3, 1'b0);
    ENABLE = 1'b1;
    wait_falls(5);
    ENABLE = 1'b0;
    wait_frames(exp_total);
    repeat (8) @(negedge CLK);
    check_idle("stop idle");
    check("stop I_RDY", I_RDY, 1);

    // Full FIFO: push coincides with frame-start pop
    push(16'h1234);
    push(16'h5678);
    push(16'h9ABC);
    check("collision pre-full", I_RDY, 0);
    ENABLE = 1'b1;
    I_DV   = 1'b1;
    DI     = 16'hFEDC;
    @(negedge CLK);
    check("collision O_OVF", O_OVF, 0);
    check("collision still full", I_RDY, 0);
    DI = 16'hDEAD;
    @(negedge CLK);
    I_DV = 1'b0;
    check("post-collision O_OVF", O_OVF, 1);
    expect_frame(16'h3C5A, 1'b0);
    expect_frame(16'h1234, 1'b0);
    expect_frame(16'h5678, 1'b0);
    expect_frame(16'h9ABC, 1'b0);
    expect_frame(16'hFEDC, 1'b0);
    expect_frame(16'h0000, 1'b1);
    run_until_last();
    check_idle("collision idle");

    // Reset at bit 20 with three samples queued
    push(16'h0F0F);
    push(16'hF0F0);
    push(16'h1357);
    ENABLE = 1'b1;
    wait_falls(20);
    #3 NRESET = 1'b0;
    #1;
    check("async reset SCLK", SCLK, 0);
    check("async reset LRCLK", LRCLK, 0);
    check("async reset SDATA", SDATA, 0);
    check("async reset I_RDY", I_RDY, 1);
    repeat (3) @(negedge CLK);
    NRESET = 1'b1;
    expect_frame(16'h0000, 1'b1);
    @(negedge CLK);
    check("O_UNF after reset", O_UNF, 1);
    run_until_last();
    check_idle("reset idle");

    check("expect queue drained", exp_q.size(), 0);
    check("frame count", frames_done, exp_total);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
